// File: rtl/fp32_mult_responder.sv
// fp32_mult_responder: binary32 multiplier behind a stb/ack operand handshake, denormals flushed, round-to-nearest-even.
module fp32_mult_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  typedef enum logic [2:0] {GET_A, GET_B, UNPACK, MULT, NORM, ROUND, PACK, PUT_Z} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic [47:0] p_q, p_d;
  logic signed [9:0] e_q, e_d;
  logic [23:0] m_q, m_d;
  logic g_q, g_d, s_q, s_d;
  logic a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
  logic [7:0] ea, eb;
  logic [23:0] ma, mb;
  logic sz, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign ma = {1'b1, a_q[22:0]};
  assign mb = {1'b1, b_q[22:0]};
  assign sz = a_q[31] ^ b_q[31];
  assign a_zero = ea == 8'h00;
  assign b_zero = eb == 8'h00;
  assign a_inf = ea == 8'hFF && a_q[22:0] == 23'h0;
  assign b_inf = eb == 8'hFF && b_q[22:0] == 23'h0;
  assign a_nan = ea == 8'hFF && a_q[22:0] != 23'h0;
  assign b_nan = eb == 8'hFF && b_q[22:0] != 23'h0;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    z_d = z_q;
    p_d = p_q;
    e_d = e_q;
    m_d = m_q;
    g_d = g_q;
    s_d = s_q;
    a_ack_d = a_ack_q;
    b_ack_d = b_ack_q;
    z_stb_d = z_stb_q;
    case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && input_a_stb) begin
          a_d = input_a;
          a_ack_d = 1'b0;
          b_ack_d = 1'b1;
          state_d = GET_B;
        end
      end
      GET_B: begin
        b_ack_d = 1'b1;
        if (b_ack_q && input_b_stb) begin
          b_d = input_b;
          b_ack_d = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        state_d = MULT;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          z_d = 32'h7FC00000;
          z_stb_d = 1'b1;
          state_d = PUT_Z;
        end else if (a_inf || b_inf) begin
          z_d = {sz, 8'hFF, 23'h0};
          z_stb_d = 1'b1;
          state_d = PUT_Z;
        end else if (a_zero || b_zero) begin
          z_d = {sz, 31'h0};
          z_stb_d = 1'b1;
          state_d = PUT_Z;
        end
      end
      MULT: begin
        p_d = {24'h0, ma} * {24'h0, mb};
        e_d = {2'b00, ea} + {2'b00, eb} - 10'd127;
        state_d = NORM;
      end
      NORM: begin
        m_d = p_q[47] ? p_q[47:24] : p_q[46:23];
        g_d = p_q[47] ? p_q[23] : p_q[22];
        s_d = p_q[47] ? |p_q[22:0] : |p_q[21:0];
        e_d = p_q[47] ? e_q + 10'sd1 : e_q;
        state_d = ROUND;
      end
      ROUND: begin
        if (g_q && (s_q || m_q[0])) begin
          m_d = &m_q ? 24'h800000 : m_q + 24'd1;
          e_d = &m_q ? e_q + 10'sd1 : e_q;
        end
        state_d = PACK;
      end
      PACK: begin
        z_d = e_q >= 10'sd255 ? {sz, 8'hFF, 23'h0} :
              e_q <= 10'sd0 ? {sz, 31'h0} : {sz, e_q[7:0], m_q[22:0]};
        z_stb_d = 1'b1;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (output_z_ack) begin
          z_stb_d = 1'b0;
          a_ack_d = 1'b1;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    p_q <= p_d;
    e_q <= e_d;
    m_q <= m_d;
    g_q <= g_d;
    s_q <= s_d;
    if (rst) begin
      state_q <= GET_A;
      z_q <= 32'h0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q <= z_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;
    end
  end
  assign input_a_ack = a_ack_q;
  assign input_b_ack = b_ack_q;
  assign output_z = z_q;
  assign output_z_stb = z_stb_q;
endmodule
